// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param: memory-game core. It shows a growing sequence of
// one-hot LEDs and then checks the player's button presses against it.
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   jogar          start/restart request, honoured only in INICIAL and FIM_*
//   configuracao   [0]=1 long game (MAX_RODADAS), [1]=1 press timeout enabled;
//                  latched when a game starts
//   botoes         player buttons (already synchronised)
//   leds           sequence display (registered, one cycle behind MOSTRA)
//   ganhou/perdeu/timeout  outcome flags, held while in the matching FIM_*
//   pronto         game ended with any outcome
//   db_estado      current state code
//   db_rodada      current round, 1-based (0 after reset)
//   db_jogada      last registered press
//
// The buttons have no valid/ready pair. A press is the first cycle on which
// botoes is non-zero after a cycle on which it was all-zero. Holding a button
// therefore produces exactly one press.
module jogo_memoria_param #(
  parameter int NUM_BOTOES    = 4,
  parameter int MAX_RODADAS   = 16,
  parameter int RODADAS_CURTO = 4,
  parameter int TEMPO_LED     = 1000,
  parameter int TEMPO_APAGADO = 500,
  parameter int TEMPO_TIMEOUT = 5000,
  parameter logic [MAX_RODADAS*NUM_BOTOES-1:0] SEQUENCIA = 64'h8421_2418_4812_1248
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               jogar,
  input  logic [1:0]                         configuracao,
  input  logic [NUM_BOTOES-1:0]              botoes,
  output logic [NUM_BOTOES-1:0]              leds,
  output logic                               ganhou,
  output logic                               perdeu,
  output logic                               timeout,
  output logic                               pronto,
  output logic [4:0]                         db_estado,
  output logic [$clog2(MAX_RODADAS+1)-1:0]   db_rodada,
  output logic [NUM_BOTOES-1:0]              db_jogada
);

  localparam int RW     = $clog2(MAX_RODADAS+1);
  localparam int TMAX_A = (TEMPO_LED > TEMPO_APAGADO) ? TEMPO_LED : TEMPO_APAGADO;
  localparam int TMAX   = (TMAX_A > TEMPO_TIMEOUT) ? TMAX_A : TEMPO_TIMEOUT;
  localparam int TW     = $clog2(TMAX+1);

  typedef enum logic [4:0] {
    INICIAL       = 5'd0,
    PREPARA       = 5'd1,
    INICIA_RODADA = 5'd2,
    MOSTRA        = 5'd3,
    APAGA         = 5'd4,
    PROX_LED      = 5'd5,
    INICIA_JOGADA = 5'd6,
    ESPERA        = 5'd7,
    COMPARA       = 5'd8,
    PROX_JOGADA   = 5'd9,
    FIM_GANHOU    = 5'd10,
    FIM_PERDEU    = 5'd11,
    FIM_TIMEOUT   = 5'd12
  } estado_t;

  estado_t               state, state_next;
  logic [TW-1:0]         tmr;
  logic [RW-1:0]         rodada;
  logic [RW-1:0]         endereco;
  logic [NUM_BOTOES-1:0] botoes_prev;
  logic                  cfg_longo;
  logic                  cfg_timeout;
  logic [NUM_BOTOES-1:0] seq_el;
  logic [RW-1:0]         limite;
  logic                  ultimo;
  logic                  press;

  assign seq_el = SEQUENCIA[int'(endereco)*NUM_BOTOES +: NUM_BOTOES];
  assign limite = cfg_longo ? RW'(MAX_RODADAS) : RW'(RODADAS_CURTO);
  assign ultimo = ((endereco + RW'(1)) == rodada);
  assign press  = (botoes != '0) && (botoes_prev == '0);

  assign db_estado = state;
  assign db_rodada = rodada;

  always_ff @(posedge clock) begin
    if (reset) state <= INICIAL;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INICIAL:       if (jogar) state_next = PREPARA;
      PREPARA:       state_next = INICIA_RODADA;
      INICIA_RODADA: state_next = MOSTRA;
      MOSTRA:        if (tmr == TW'(TEMPO_LED-1)) state_next = APAGA;
      APAGA:         if (tmr == TW'(TEMPO_APAGADO-1)) state_next = PROX_LED;
      PROX_LED:      state_next = ultimo ? INICIA_JOGADA : MOSTRA;
      INICIA_JOGADA: state_next = ESPERA;
      ESPERA: begin
        // A press on the expiry cycle takes priority over the timeout.
        if (press)
          state_next = COMPARA;
        else if (cfg_timeout && (tmr == TW'(TEMPO_TIMEOUT-1)))
          state_next = FIM_TIMEOUT;
      end
      COMPARA: begin
        if (db_jogada != seq_el)   state_next = FIM_PERDEU;
        else if (!ultimo)          state_next = PROX_JOGADA;
        else if (rodada == limite) state_next = FIM_GANHOU;
        else                       state_next = INICIA_RODADA;
      end
      PROX_JOGADA:   state_next = ESPERA;
      FIM_GANHOU,
      FIM_PERDEU,
      FIM_TIMEOUT:   if (jogar) state_next = PREPARA;
      default:       state_next = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tmr         <= '0;
      rodada      <= '0;
      endereco    <= '0;
      botoes_prev <= '0;
      cfg_longo   <= 1'b0;
      cfg_timeout <= 1'b0;
      db_jogada   <= '0;
      leds        <= '0;
      ganhou      <= 1'b0;
      perdeu      <= 1'b0;
      timeout     <= 1'b0;
      pronto      <= 1'b0;
    end else begin
      botoes_prev <= botoes;

      // One timer serves every timed state: it restarts on each state change
      // and saturates so a long wait with the timeout disabled cannot wrap.
      if (state_next != state)  tmr <= '0;
      else if (tmr != TW'(TMAX)) tmr <= tmr + TW'(1);

      case (state)
        PREPARA: begin
          cfg_longo   <= configuracao[0];
          cfg_timeout <= configuracao[1];
          rodada      <= RW'(1);
        end
        INICIA_RODADA: endereco <= '0;
        PROX_LED:      if (!ultimo) endereco <= endereco + RW'(1);
        INICIA_JOGADA: endereco <= '0;
        ESPERA:        if (press) db_jogada <= botoes;
        COMPARA:       if (state_next == INICIA_RODADA) rodada <= rodada + RW'(1);
        PROX_JOGADA:   endereco <= endereco + RW'(1);
        default: ;
      endcase

      leds    <= (state == MOSTRA) ? seq_el : '0;
      // Flags follow the next state so they line up with db_estado and are
      // cleared as soon as a FIM_* state is left.
      ganhou  <= (state_next == FIM_GANHOU);
      perdeu  <= (state_next == FIM_PERDEU);
      timeout <= (state_next == FIM_TIMEOUT);
      pronto  <= (state_next == FIM_GANHOU) || (state_next == FIM_PERDEU) ||
                 (state_next == FIM_TIMEOUT);
    end
  end

endmodule

// File: tb/tb_jogo_memoria_param.sv
module tb_jogo_memoria_param;

  localparam logic [4:0] S_INICIAL     = 5'b00000;
  localparam logic [4:0] S_PREPARA     = 5'b00001;
  localparam logic [4:0] S_INICIA_ROD  = 5'b00010;
  localparam logic [4:0] S_MOSTRA      = 5'b00011;
  localparam logic [4:0] S_ESPERA      = 5'b00111;
  localparam logic [4:0] S_COMPARA     = 5'b01000;
  localparam logic [4:0] S_FIM_GANHOU  = 5'b01010;
  localparam logic [4:0] S_FIM_PERDEU  = 5'b01011;
  localparam logic [4:0] S_FIM_TIMEOUT = 5'b01100;

  // clock/reset block
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       jogar;
  logic [1:0] configuracao;
  logic [3:0] botoes;
  logic [3:0] leds;
  logic       ganhou, perdeu, timeout, pronto;
  logic [4:0] db_estado;
  logic [4:0] db_rodada;
  logic [3:0] db_jogada;

  int checks = 0;
  int errors = 0;

  // Expected sequence elements 0..3 of the default ROM.
  logic [3:0] exp_q[$] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

  jogo_memoria_param #(
    .TEMPO_LED(4), .TEMPO_APAGADO(2), .TEMPO_TIMEOUT(20)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .configuracao(configuracao),
    .botoes(botoes), .leds(leds), .ganhou(ganhou), .perdeu(perdeu),
    .timeout(timeout), .pronto(pronto), .db_estado(db_estado),
    .db_rodada(db_rodada), .db_jogada(db_jogada)
  );

  // driver tasks (all start and end at a falling edge)
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_state(input logic [4:0] code, input int budget, input string tag);
    int n = 0;
    while (db_estado !== code && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, db_estado, code);
  endtask

  task automatic start_game();
    jogar = 1'b1;
    step(1);
    jogar = 1'b0;
    chk("start_prepara", db_estado, S_PREPARA);
  endtask

  task automatic press(input logic [3:0] v);
    botoes = v;
    step(1);
    botoes = 4'b0000;
    step(1);
  endtask

  task automatic play_round(input int r);
    for (int k = 0; k < r; k++) begin
      wait_state(S_ESPERA, 200, "round_espera");
      if (k == 0) chk("round_num", db_rodada, r);
      press(exp_q[k]);
      chk("round_jogada", db_jogada, exp_q[k]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; jogar = 1'b0; configuracao = 2'b00; botoes = 4'b0000;
    step(1);

    // 1: reset state
    chk("rst_estado", db_estado, S_INICIAL);
    chk("rst_leds", leds, 4'b0000);
    chk("rst_ganhou", ganhou, 1'b0);
    chk("rst_perdeu", perdeu, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_pronto", pronto, 1'b0);
    chk("rst_rodada", db_rodada, 5'd0);
    reset = 1'b0;
    step(2);
    chk("idle_stays", db_estado, S_INICIAL);

    // 2: full short game won
    configuracao = 2'b00;
    start_game();
    for (int r = 1; r <= 4; r++) play_round(r);
    wait_state(S_FIM_GANHOU, 20, "win_estado");
    chk("win_ganhou", ganhou, 1'b1);
    chk("win_pronto", pronto, 1'b1);
    chk("win_perdeu", perdeu, 1'b0);
    chk("win_rodada", db_rodada, 5'd4);
    chk("win_leds", leds, 4'b0000);

    // 3: multi-hot press loses
    start_game();
    chk("restart_ganhou_clr", ganhou, 1'b0);
    wait_state(S_ESPERA, 200, "lose_espera");
    press(4'b1100);
    wait_state(S_FIM_PERDEU, 10, "lose_estado");
    chk("lose_perdeu", perdeu, 1'b1);
    chk("lose_pronto", pronto, 1'b1);
    chk("lose_jogada", db_jogada, 4'b1100);
    chk("lose_ganhou", ganhou, 1'b0);

    // 5: restart from FIM_PERDEU and watch the first LED
    start_game();
    chk("re_perdeu_clr", perdeu, 1'b0);
    chk("re_pronto_clr", pronto, 1'b0);
    wait_state(S_MOSTRA, 20, "re_mostra");
    chk("re_rodada", db_rodada, 5'd1);
    chk("re_leds_lag", leds, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("re_leds_on", leds, 4'b1000);
    end
    step(1);
    chk("re_leds_off", leds, 4'b0000);

    // 4b: timeout disabled (latched 00); a mid-game config change is ignored
    configuracao = 2'b10;
    wait_state(S_ESPERA, 50, "nto_espera");
    step(30);
    chk("nto_estado", db_estado, S_ESPERA);
    chk("nto_timeout", timeout, 1'b0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;

    // 4: timeout enabled, expires after exactly 20 waiting cycles
    start_game();
    wait_state(S_ESPERA, 50, "to_espera");
    step(19);
    chk("to_not_yet", db_estado, S_ESPERA);
    chk("to_flag_low", timeout, 1'b0);
    step(1);
    chk("to_estado", db_estado, S_FIM_TIMEOUT);
    chk("to_flag", timeout, 1'b1);
    chk("to_pronto", pronto, 1'b1);

    // press on the expiry cycle wins
    start_game();
    wait_state(S_ESPERA, 50, "tie_espera");
    step(19);
    botoes = 4'b1000;
    step(1);
    chk("tie_compara", db_estado, S_COMPARA);
    botoes = 4'b0000;
    step(1);
    chk("tie_next", db_estado, S_INICIA_ROD);
    chk("tie_timeout", timeout, 1'b0);

    // 6: reset during round-3 display
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    configuracao = 2'b00;
    start_game();
    play_round(1);
    play_round(2);
    wait_state(S_MOSTRA, 50, "r3_mostra");
    step(1);
    chk("r3_rodada", db_rodada, 5'd3);
    chk("r3_leds", leds, 4'b1000);
    reset = 1'b1;
    step(1);
    chk("midrst_estado", db_estado, S_INICIAL);
    chk("midrst_leds", leds, 4'b0000);
    chk("midrst_rodada", db_rodada, 5'd0);
    reset = 1'b0;

    // held button counts as one press
    start_game();
    play_round(1);
    wait_state(S_ESPERA, 200, "hold_espera");
    chk("hold_rodada", db_rodada, 5'd2);
    botoes = 4'b1000;
    step(10);
    botoes = 4'b0000;
    step(1);
    chk("hold_estado", db_estado, S_ESPERA);
    chk("hold_perdeu", perdeu, 1'b0);
    chk("hold_jogada", db_jogada, 4'b1000);
    press(4'b0100);
    chk("hold_next_estado", db_estado, S_INICIA_ROD);
    chk("hold_next_rodada", db_rodada, 5'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
